// File: rtl/text_pixel_gen.sv
// text_pixel_gen
//
// Text-mode pixel pipeline that sits in front of the character generator.
// It walks a 32x16 text screen in step with the display enable, fetches
// character codes from a registered video RAM, drives the character
// generator address and serializes the returned glyph rows into a 1-bit
// pixel stream with per-character inverse video (code bit 7).
//
// Optional feature macro: SEMIGRAPHICS_EN
//   When defined, codes with bit 6 set are drawn as 2x3 block graphics
//   instead of going through the character generator.
//
// Ports:
//   clk          pixel clock, the only clock
//   reset        asynchronous, active-high reset
//   de           display enable from the timing generator
//   frame_start  one-cycle pulse before the first active scanline
//   vram_addr    video RAM address {text_row, col}
//   vram_data    video RAM read data (one cycle after vram_addr)
//   cg_addr      character generator address {code[5:0], glyph_row}
//   cg_data      character generator row pattern (combinational)
//   pixel        registered pixel, 1 = foreground
//   de_out       display enable delayed to line up with pixel

module text_pixel_gen #(
    parameter int SCANLINES_PER_ROW = 12,
    parameter int TEXT_ROWS         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       de,
    input  logic       frame_start,
    output logic [8:0] vram_addr,
    input  logic [7:0] vram_data,
    output logic [9:0] cg_addr,
    input  logic [7:0] cg_data,
    output logic       pixel,
    output logic       de_out
);

    localparam logic [3:0] LAST_GLYPH_ROW = 4'(SCANLINES_PER_ROW - 1);
    localparam logic [3:0] LAST_TEXT_ROW  = 4'(TEXT_ROWS - 1);

    logic [7:0] x_q,        x_d;
    logic [3:0] glyphRow_q, glyphRow_d;
    logic [3:0] textRow_q,  textRow_d;
    logic       armed_q,    armed_d;
    logic       deDly1_q,   deDly1_d;
    logic       deDly2_q,   deDly2_d;
    logic       loadDly_q,  loadDly_d;
    logic [7:0] shift_q,    shift_d;

    logic       deEff;
    logic       lineEnd;
    logic [7:0] glyphByte;
    logic [7:0] rowByte;

    // After a reset that lands in the middle of a line, the remainder of
    // that line is ignored: the pipeline only starts once de has been seen
    // low, so every line it draws begins at x = 0.
    assign deEff   = de & armed_q;
    assign lineEnd = deDly1_q & ~deEff;

    assign vram_addr = {textRow_q, x_q[7:3]};
    assign cg_addr   = {vram_data[5:0], glyphRow_q};
    assign pixel     = shift_q[7];
    assign de_out    = deDly2_q;

    // Select the row pattern for the character whose code has just come back
    // from video RAM, then apply inverse video from code bit 7.
`ifdef SEMIGRAPHICS_EN
    logic semiHi;
    logic semiLo;

    always_comb begin
        semiHi = 1'b0;
        semiLo = 1'b0;
        unique case (glyphRow_q[3:2])
            2'd0:    begin semiHi = vram_data[5]; semiLo = vram_data[4]; end
            2'd1:    begin semiHi = vram_data[3]; semiLo = vram_data[2]; end
            2'd2:    begin semiHi = vram_data[1]; semiLo = vram_data[0]; end
            default: begin semiHi = 1'b0;         semiLo = 1'b0;         end
        endcase
        glyphByte = cg_data;
        if (vram_data[6]) begin
            glyphByte = {{4{semiHi}}, {4{semiLo}}};
        end
        rowByte = glyphByte ^ {8{vram_data[7]}};
    end
`else
    logic unusedCodeBit6;
    assign unusedCodeBit6 = vram_data[6];

    always_comb begin
        glyphByte = cg_data;
        rowByte   = glyphByte ^ {8{vram_data[7]}};
    end
`endif

    // Next-state logic for the scan counters, the de/load delay line and
    // the pixel shift register. The load of a new glyph row happens on the
    // same edge that would otherwise shift out the last bit of the previous
    // one, so characters follow each other with no gap pixels.
    always_comb begin
        armed_d    = armed_q | ~de;
        x_d        = deEff ? (x_q + 8'd1) : 8'd0;
        deDly1_d   = deEff;
        deDly2_d   = deDly1_q;
        loadDly_d  = deEff && (x_q[2:0] == 3'd0);
        glyphRow_d = glyphRow_q;
        textRow_d  = textRow_q;
        shift_d    = shift_q;

        if (frame_start) begin
            glyphRow_d = 4'd0;
            textRow_d  = 4'd0;
        end else if (lineEnd) begin
            if (glyphRow_q == LAST_GLYPH_ROW) begin
                glyphRow_d = 4'd0;
                textRow_d  = (textRow_q == LAST_TEXT_ROW) ? 4'd0 : (textRow_q + 4'd1);
            end else begin
                glyphRow_d = glyphRow_q + 4'd1;
            end
        end

        if (!deDly1_q) begin
            shift_d = 8'd0;
        end else if (loadDly_q) begin
            shift_d = rowByte;
        end else begin
            shift_d = {shift_q[6:0], 1'b0};
        end
    end

    // State registers, all cleared by the asynchronous reset so pixel and
    // de_out drop immediately when reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q        <= 8'd0;
            glyphRow_q <= 4'd0;
            textRow_q  <= 4'd0;
            armed_q    <= 1'b0;
            deDly1_q   <= 1'b0;
            deDly2_q   <= 1'b0;
            loadDly_q  <= 1'b0;
            shift_q    <= 8'd0;
        end else begin
            x_q        <= x_d;
            glyphRow_q <= glyphRow_d;
            textRow_q  <= textRow_d;
            armed_q    <= armed_d;
            deDly1_q   <= deDly1_d;
            deDly2_q   <= deDly2_d;
            loadDly_q  <= loadDly_d;
            shift_q    <= shift_d;
        end
    end

endmodule
